// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: RV32I opcode classes,
// 12-bit ALU operation codes {bit11, bit10, funct3, opcode} and FSM states.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [11:0] ALUOP_ADD  = 12'b000000110011;
  localparam logic [11:0] ALUOP_SUB  = 12'b100000110011;
  localparam logic [11:0] ALUOP_SRA  = 12'b101010110011;
  localparam logic [11:0] ALUOP_ADDI = 12'b000000010011;
  localparam logic [11:0] ALUOP_SRAI = 12'b011010010011;
  localparam logic [11:0] ALUOP_BEQ  = 12'b000001100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  function automatic logic [11:0] mk_op(input logic b11, input logic b10,
                                        input logic [2:0] f3, input logic [6:0] opc);
    return {b11, b10, f3, opc};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake between fetch (master) and the issue sequencer (slave).
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decoder: op code, I-immediate, B-offset,
// class flags and legality for OP / OP-IMM / BRANCH.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [11:0] o_op,
  output logic [31:0] o_imm,
  output logic [31:0] o_br_offset,
  output logic        o_is_branch,
  output logic        o_writes_rd,
  output logic        o_legal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_f7_zero;
  logic       w_f7_alt;
  logic       w_rd_nz;
  logic       w_unused_rs;

  assign w_opc       = i_instr[6:0];
  assign w_f3        = i_instr[14:12];
  assign w_f7_zero   = (i_instr[31:25] == 7'b0000000);
  assign w_f7_alt    = (i_instr[31:25] == 7'b0100000);
  assign w_rd_nz     = (i_instr[11:7] != 5'd0);
  assign w_unused_rs = ^i_instr[19:15];

  assign o_br_offset = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};

  always_comb begin
    o_op        = mk_op(1'b0, 1'b0, w_f3, w_opc);
    o_imm       = '0;
    o_is_branch = 1'b0;
    o_writes_rd = 1'b0;
    o_legal     = 1'b0;
    case (w_opc)
      OPC_OP: begin
        o_op        = mk_op(i_instr[30], 1'b0, w_f3, w_opc);
        o_legal     = w_f7_zero || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101));
        o_writes_rd = w_rd_nz;
      end
      OPC_OPIMM: begin
        // funct7 only matters for shifts; bit 10 distinguishes srai from srli
        o_op        = mk_op(1'b0, (w_f3 == 3'b101) && i_instr[30], w_f3, w_opc);
        o_imm       = {{20{i_instr[31]}}, i_instr[31:20]};
        o_writes_rd = w_rd_nz;
        case (w_f3)
          3'b001:  o_legal = w_f7_zero;
          3'b101:  o_legal = w_f7_zero || w_f7_alt;
          default: o_legal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        o_is_branch = 1'b1;
        o_legal     = !(w_f3 == 3'b010 || w_f3 == 3'b011);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for the registered ALU: IDLE -> EXEC -> WB, or
// IDLE -> TRAP for unsupported words. Optional ALU_ISSUE_PERF_EN adds a retire counter.
module alu_issue
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_issue_if.slave         instr_if,
  output logic [4:0]         o_rf_raddr1,
  output logic [4:0]         o_rf_raddr2,
  input  logic [31:0]        i_rf_rdata1,
  input  logic [31:0]        i_rf_rdata2,
  output logic [11:0]        o_alu_operation,
  output logic [31:0]        o_alu_rs1,
  output logic [31:0]        o_alu_rs2,
  output logic [31:0]        o_alu_imm,
  input  logic [31:0]        i_alu_rd,
  input  logic               i_alu_zero,
  output logic               o_rf_we,
  output logic [4:0]         o_rf_waddr,
  output logic [31:0]        o_rf_wdata,
  output logic               o_br_valid,
  output logic               o_br_taken,
  output logic [31:0]        o_br_offset,
  output logic               o_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]        o_perf_retired
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic        w_ready;
  logic        w_accept;
  logic        w_trap;

  logic [11:0] w_dec_op;
  logic [31:0] w_dec_imm;
  logic [31:0] w_dec_boff;
  logic        w_dec_is_branch;
  logic        w_dec_writes_rd;
  logic        w_dec_legal;

  logic [11:0] r_alu_op;
  logic [31:0] r_alu_rs1;
  logic [31:0] r_alu_rs2;
  logic [31:0] r_alu_imm;
  logic [31:0] r_br_offset;
  logic [4:0]  r_rd;
  logic        r_is_branch;
  logic        r_writes_rd;
  logic        r_rf_we;
  logic        r_br_valid;
  logic        r_illegal;

  alu_issue_decode u_decode (
    .i_instr     (instr_if.instr),
    .o_op        (w_dec_op),
    .o_imm       (w_dec_imm),
    .o_br_offset (w_dec_boff),
    .o_is_branch (w_dec_is_branch),
    .o_writes_rd (w_dec_writes_rd),
    .o_legal     (w_dec_legal)
  );

  assign o_rf_raddr1 = instr_if.instr[19:15];
  assign o_rf_raddr2 = instr_if.instr[24:20];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_trap   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (instr_if.instr_valid) begin
          w_accept = w_dec_legal;
          w_trap   = !w_dec_legal;
          w_next   = w_dec_legal ? ST_EXEC : ST_TRAP;
        end
      end
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      ST_TRAP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Issue stage: operands captured on the handshake edge, strobes armed one edge ahead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_op    <= '0;
      r_alu_rs1   <= '0;
      r_alu_rs2   <= '0;
      r_alu_imm   <= '0;
      r_br_offset <= '0;
      r_rd        <= '0;
      r_is_branch <= 1'b0;
      r_writes_rd <= 1'b0;
      r_rf_we     <= 1'b0;
      r_br_valid  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_op    <= w_dec_op;
        r_alu_rs1   <= i_rf_rdata1;
        r_alu_rs2   <= i_rf_rdata2;
        r_alu_imm   <= w_dec_imm;
        r_br_offset <= w_dec_boff;
        r_rd        <= instr_if.instr[11:7];
        r_is_branch <= w_dec_is_branch;
        r_writes_rd <= w_dec_writes_rd;
      end
      r_rf_we    <= (r_state == ST_EXEC) && r_writes_rd;
      r_br_valid <= (r_state == ST_EXEC) && r_is_branch;
      r_illegal  <= w_trap;
    end
  end

  // Writeback stage: ALU result and flag are only meaningful while a strobe is up
  assign instr_if.instr_ready = w_ready;
  assign o_alu_operation      = r_alu_op;
  assign o_alu_rs1            = r_alu_rs1;
  assign o_alu_rs2            = r_alu_rs2;
  assign o_alu_imm            = r_alu_imm;
  assign o_br_offset          = r_br_offset;
  assign o_rf_we              = r_rf_we;
  assign o_rf_waddr           = r_rd;
  assign o_rf_wdata           = r_rf_we ? i_alu_rd : 32'd0;
  assign o_br_valid           = r_br_valid;
  assign o_br_taken           = r_br_valid && i_alu_zero;
  assign o_illegal            = r_illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_perf_retired <= '0;
    else if (r_state == ST_WB)  r_perf_retired <= r_perf_retired + 32'd1;
  end

  assign o_perf_retired = r_perf_retired;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a cycle-count behavioural model and a
// per-cycle compare process; also checks perf_retired when ALU_ISSUE_PERF_EN is set.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if u_if();

  logic [31:0] rd1, rd2, alu_rd;
  logic        alu_zero;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [11:0] alu_op;
  logic [31:0] alu_rs1, alu_rs2, alu_imm, wdata, boff;
  logic        rf_we, br_valid, br_taken, illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf;
`endif

  int total = 0;
  int bad   = 0;

  alu_issue dut (
    .clk             (clk),
    .rst             (rst),
    .instr_if        (u_if),
    .o_rf_raddr1     (raddr1),
    .o_rf_raddr2     (raddr2),
    .i_rf_rdata1     (rd1),
    .i_rf_rdata2     (rd2),
    .o_alu_operation (alu_op),
    .o_alu_rs1       (alu_rs1),
    .o_alu_rs2       (alu_rs2),
    .o_alu_imm       (alu_imm),
    .i_alu_rd        (alu_rd),
    .i_alu_zero      (alu_zero),
    .o_rf_we         (rf_we),
    .o_rf_waddr      (waddr),
    .o_rf_wdata      (wdata),
    .o_br_valid      (br_valid),
    .o_br_taken      (br_taken),
    .o_br_offset     (boff),
    .o_illegal       (illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .o_perf_retired  (perf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Expected decode straight from the instruction-set rules
  typedef struct packed {
    logic        legal;
    logic        isbr;
    logic [4:0]  rd;
    logic [11:0] op;
    logic [31:0] imm;
    logic [31:0] boff;
  } dec_t;

  function automatic dec_t mdec(input logic [31:0] w);
    dec_t d;
    int   b;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    b   = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    d      = '0;
    d.rd   = w[11:7];
    d.boff = b;
    if (opc == 7'h33) begin
      d.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      d.op    = {w[30], 1'b0, f3, opc};
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1)      d.legal = (f7 == 7'h00);
      else if (f3 == 3'd5) d.legal = (f7 == 7'h00) || (f7 == 7'h20);
      else                 d.legal = 1'b1;
      d.op  = {1'b0, (f3 == 3'd5) ? w[30] : 1'b0, f3, opc};
      d.imm = 32'($signed(w[31:20]));
    end else if (opc == 7'h63) begin
      d.legal = !(f3 == 3'd2 || f3 == 3'd3);
      d.isbr  = 1'b1;
      d.op    = {2'b00, f3, opc};
    end
    return d;
  endfunction

  dec_t d_now;
  assign d_now = mdec(u_if.instr);

  // k counts cycles since the handshake: 0 idle, 1 exec/trap, 2 writeback
  int          k = 0;
  logic        m_leg = 1'b0, m_isbr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [11:0] m_op = '0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_boff = '0, m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0; m_leg <= 1'b0; m_isbr <= 1'b0; m_rd <= '0; m_op <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_imm <= '0; m_boff <= '0; m_cnt <= '0;
    end else if (k == 0) begin
      if (u_if.instr_valid) begin
        k     <= 1;
        m_leg <= d_now.legal;
        if (d_now.legal) begin
          m_isbr <= d_now.isbr; m_rd <= d_now.rd; m_op <= d_now.op;
          m_rs1 <= rd1; m_rs2 <= rd2; m_imm <= d_now.imm; m_boff <= d_now.boff;
        end
      end
    end else if (k == 1 && m_leg) begin
      k <= 2;
    end else begin
      if (k == 2) m_cnt <= m_cnt + 32'd1;
      k <= 0;
    end
  end

  always @(negedge clk) begin
    logic e_we, e_bv, e_ill;
    e_we  = (k == 2) && !m_isbr && (m_rd != 5'd0);
    e_bv  = (k == 2) && m_isbr;
    e_ill = (k == 1) && !m_leg;
    chk("ready",    32'(u_if.instr_ready), 32'(k == 0));
    chk("rf_we",    32'(rf_we),    32'(e_we));
    chk("br_valid", 32'(br_valid), 32'(e_bv));
    chk("illegal",  32'(illegal),  32'(e_ill));
    chk("excl",     32'(int'(rf_we) + int'(br_valid) + int'(illegal) <= 1), 32'd1);
    if (e_we) begin
      chk("waddr", 32'(waddr), 32'(m_rd));
      chk("wdata", wdata, alu_rd);
    end
    if (e_bv) chk("taken", 32'(br_taken), 32'(alu_zero));
    chk("alu_op",  32'(alu_op), 32'(m_op));
    chk("alu_rs1", alu_rs1, m_rs1);
    chk("alu_rs2", alu_rs2, m_rs2);
    chk("alu_imm", alu_imm, m_imm);
    chk("br_off",  boff, m_boff);
    chk("raddr1",  32'(raddr1), 32'(u_if.instr[19:15]));
    chk("raddr2",  32'(raddr2), 32'(u_if.instr[24:20]));
`ifdef ALU_ISSUE_PERF_EN
    chk("perf", perf, m_cnt);
`endif
  end

  // Offer one word in IDLE, then check literal expectations at T+1, T+2 (and T+3)
  task automatic issue(input string nm, input logic [31:0] w, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic z,
                       input logic [11:0] eop, input logic [31:0] eimm, input int cyc,
                       input logic ewe, input logic [4:0] ewa, input logic ebv,
                       input logic etk);
    u_if.instr_valid = 1'b1;
    u_if.instr       = w;
    rd1 = a;
    rd2 = b;
    @(posedge clk); #1;
    u_if.instr = 32'hFFFF_FFFF;
    rd1 = 32'hDEAD_BEEF;
    rd2 = 32'hCAFE_F00D;
    alu_rd   = r;
    alu_zero = z;
    chk({nm, ".op"},  32'(alu_op), 32'(eop));
    chk({nm, ".imm"}, alu_imm, eimm);
    chk({nm, ".ill"}, 32'(illegal), 32'(cyc == 2));
    @(posedge clk); #1;
    if (cyc == 3) begin
      chk({nm, ".we"}, 32'(rf_we), 32'(ewe));
      chk({nm, ".bv"}, 32'(br_valid), 32'(ebv));
      if (ewe) begin
        chk({nm, ".wa"}, 32'(waddr), 32'(ewa));
        chk({nm, ".wd"}, wdata, r);
      end
      if (ebv) chk({nm, ".tk"}, 32'(br_taken), 32'(etk));
      @(posedge clk); #1;
    end
    chk({nm, ".rdy"}, 32'(u_if.instr_ready), 32'd1);
    u_if.instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.instr_valid = 1'b0;
    u_if.instr       = 32'h0;
    rd1 = 32'h0; rd2 = 32'h0; alu_rd = 32'h0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(u_if.instr_ready), 32'd1);
    chk("rst.op",    32'(alu_op), 32'd0);
    chk("rst.rs1",   alu_rs1, 32'd0);
    chk("rst.imm",   alu_imm, 32'd0);
    chk("rst.boff",  boff, 32'd0);
    chk("rst.strb",  32'({rf_we, br_valid, illegal}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("addi",  32'hFFD08293, 32'd10,        32'h55,  32'd7,        1'b0, 12'b000000010011, 32'hFFFFFFFD, 3, 1'b1, 5'd5, 1'b0, 1'b0);
    issue("sub",   32'h402081B3, 32'd100,       32'd30,  32'd70,       1'b0, 12'b100000110011, 32'h0,        3, 1'b1, 5'd3, 1'b0, 1'b0);
    issue("srai",  32'h4030D213, 32'h80000000,  32'd0,   32'hF0000000, 1'b0, 12'b011010010011, 32'h00000403, 3, 1'b1, 5'd4, 1'b0, 1'b0);
    issue("beq1",  32'h00208463, 32'd9,         32'd9,   32'd0,        1'b1, 12'b000001100011, 32'h0,        3, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("beq.off", boff, 32'd8);
    issue("beq0",  32'h00208463, 32'd9,         32'd8,   32'd1,        1'b0, 12'b000001100011, 32'h0,        3, 1'b0, 5'd0, 1'b1, 1'b0);
    issue("load",  32'h0000A103, 32'd1,         32'd2,   32'd3,        1'b0, 12'b000001100011, 32'h0,        2, 1'b0, 5'd0, 1'b0, 1'b0);
    issue("addx0", 32'h00100013, 32'd0,         32'd0,   32'd1,        1'b0, 12'b000000010011, 32'h1,        3, 1'b0, 5'd0, 1'b0, 1'b0);
    issue("badop", 32'h402091B3, 32'd5,         32'd6,   32'd7,        1'b0, 12'b000000010011, 32'h1,        2, 1'b0, 5'd0, 1'b0, 1'b0);
    issue("bf010", 32'h0020A463, 32'd5,         32'd6,   32'd7,        1'b1, 12'b000000010011, 32'h1,        2, 1'b0, 5'd0, 1'b0, 1'b0);
    issue("add",   32'h002080B3, 32'd2,         32'd3,   32'd5,        1'b0, 12'b000000110011, 32'h0,        3, 1'b1, 5'd1, 1'b0, 1'b0);

    // addi x6,x1,5 aborted by reset during EXEC
    u_if.instr_valid = 1'b1;
    u_if.instr       = 32'h00508313;
    rd1 = 32'd4;
    @(posedge clk); #1;
    u_if.instr_valid = 1'b0;
    alu_rd = 32'd9;
    #2 rst = 1'b1;
    #1;
    chk("rstx.ready", 32'(u_if.instr_ready), 32'd1);
    chk("rstx.op",    32'(alu_op), 32'd0);
    chk("rstx.we",    32'(rf_we), 32'd0);
    @(posedge clk); #1;
    chk("rstx.we2",   32'(rf_we), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstx.idle",  32'(u_if.instr_ready), 32'd1);

    issue("post",  32'hFFD08293, 32'd10,        32'd0,   32'd7,        1'b0, 12'b000000010011, 32'hFFFFFFFD, 3, 1'b1, 5'd5, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue/writeback sequencer that drives the registered ALU. It accepts one 32-bit RV32I ALU-class instruction word (OP, OP-IMM or BRANCH) through a valid/ready handshake and reads operands from the register file. It then presents the 12-bit operation code plus operands to the ALU, waits out the ALU's one-cycle registered latency, and either writes the result back or reports the branch outcome. It sits between fetch and the ALU/register file.

## Interface
- Parameters: none; datapath is fixed at 32 bits.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instr_valid`  in  1  instruction word offered
- `instr_ready`  out  1  sequencer can accept; high only in IDLE
- `instr`  in  32  instruction word
- `rf_raddr1` / `rf_raddr2`  out  5  combinational from `instr[19:15]` / `instr[24:20]`
- `rf_rdata1` / `rf_rdata2`  in  32  register file read data, combinational
- `alu_operation`  out  12  registered op code to ALU
- `alu_rs1`, `alu_rs2`, `alu_imm`  out  32  registered ALU operands
- `alu_rd`  in  32  ALU result
- `alu_zero`  in  1  ALU condition flag; 1 means the branch condition holds
- `rf_we`  out  1  one-cycle write strobe
- `rf_waddr`  out  5  write register
- `rf_wdata`  out  32  write data
- `br_valid`  out  1  one-cycle branch-resolved strobe
- `br_taken`  out  1  branch outcome, valid with `br_valid`
- `br_offset`  out  32  sign-extended B-immediate, valid with `br_valid`
- `illegal`  out  1  one-cycle strobe for an unsupported instruction

## Operation
- FSM states: IDLE, EXEC, WB, TRAP.
- IDLE:
  - Handshake when `instr_valid && instr_ready`.
  - If the instruction is legal: latch `alu_operation`, `alu_rs1`=`rf_rdata1`, `alu_rs2`=`rf_rdata2`, `alu_imm`, rd index, class and `br_offset`, then go to EXEC.
  - If illegal, go to TRAP.
- EXEC: the ALU samples its inputs at the end of this cycle; next state is WB.
- WB: `alu_rd`/`alu_zero` are valid.
  - OP/OP-IMM: `rf_we`=1 unless rd==0, with `rf_waddr`=rd and `rf_wdata`=`alu_rd`.
  - BRANCH: `br_valid`=1, `br_taken`=`alu_zero`, `rf_we`=0.
  - Next state is IDLE.
- TRAP: `illegal`=1 for one cycle, no ALU issue, next state IDLE. ALU-side registers keep their previous values.
- Op code layout: {bit11, bit10, funct3, opcode[6:0]}.
  - bit11 = `instr[30]` when opcode=0110011, else 0.
  - bit10 = `instr[30]` when opcode=0010011 and funct3=101, else 0.
- `alu_imm`:
  - OP-IMM: sign-extended `instr[31:20]`. For shifts only bits [4:0]=shamt are meaningful; bit 10 is the sra flag.
  - OP and BRANCH: 0.
- Legality:
  - OP requires funct7 of 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM slli requires funct7=0000000; srli/srai requires funct7 0000000/0100000.
  - BRANCH funct3 010/011 is illegal.
  - Any other opcode is illegal.

## Timing
- Reset:
  - State IDLE, so `instr_ready`=1.
  - All registered outputs (`alu_*`, `rf_*`, `br_*`, `illegal`) are 0.
- Latency: handshake edge T, EXEC in cycle T+1, writeback/branch strobe in cycle T+2, `instr_ready` high again in cycle T+3.
- Throughput: one instruction per 3 cycles; illegal instructions take 2 cycles.
- `instr` and `instr_valid` are sampled only in IDLE. `instr_valid` may change freely in other states.
- `rf_we`, `br_valid` and `illegal` are never high together and never high for more than one cycle.
- `rst` asserted mid-instruction:
  - Immediately forces IDLE and clears strobes.
  - The in-flight instruction is dropped with no writeback.

## Configuration
- `ALU_ISSUE_PERF_EN`:
  - Defined: adds output `perf_retired` (32 bits). It increments on every WB cycle, wraps 0xFFFFFFFF->0 and resets to 0. Illegal instructions are not counted.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg`: opcode constants, the 12-bit operation code constants, and the FSM state enum.
- Sub-module `alu_issue_decode` (combinational) produces from `instr`: op code, immediate, `br_offset`, `is_branch`, `writes_rd` and `legal`.

## Test plan
- addi x5,x1,-3: `instr`=0xFFD08293, `rf_rdata1`=10.
  - Required: `alu_operation`=000000010011, `alu_imm`=0xFFFFFFFD.
  - ALU returns 7 -> at T+2, `rf_we`=1, `rf_waddr`=5, `rf_wdata`=7.
- sub x3,x1,x2: `instr`=0x402081B3.
  - Required: `alu_operation`=100000110011; `alu_rs1`/`alu_rs2` equal the read data; writeback to x3.
- srai x4,x1,3: `instr`=0x4030D213.
  - Required: `alu_operation`=011010010011, `alu_imm[4:0]`=3.
- beq x1,x2,+8: `instr`=0x00208463, `alu_zero`=1.
  - Required: `br_valid`=1, `br_taken`=1, `br_offset`=8, `rf_we`=0.
  - Repeat with `alu_zero`=0 -> `br_taken`=0.
- Load opcode: `instr`=0x0000A103.
  - Required: `illegal` pulses at T+1; `alu_operation` unchanged; `instr_ready` high at T+2.
- addi x0,x0,1 -> `rf_we` stays 0.
  - Separately, `rst` pulsed during EXEC -> no `rf_we`, `instr_ready`=1 immediately.
  - With `ALU_ISSUE_PERF_EN` defined, `perf_retired` counts only completed instructions.
